mem_bus_arbiter: RTL

//  Two-master, one-slave arbiter on the PicoRV32 native memory interface.
//  - m0 = CPU, m1 = loader/debug master; slave = bram_controller.
//  - Round-robin grant, held until the slave returns mem_ready.
//  - Lets firmware be written or inspected while the CPU runs.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_watchdog.sv | 51 +++++
 rtl/mem_bus_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// Contents:
//   arb_state_t   - arbiter FSM states (IDLE, BUSY_M0, BUSY_M1)
//   master_id_t   - master identifier used for round-robin bookkeeping
//   ARB_ERR_RDATA - read data returned to a master whose access timed out
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_M0 = 2'd1,
    BUSY_M1 = 2'd2
  } arb_state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_t;

  localparam logic [31:0] ARB_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Slave-response watchdog for mem_bus_arbiter.
// Only compiled when MEM_ARB_TIMEOUT_EN is defined.
// Ports:
//   clk, reset_n   - clock and asynchronous active-low reset
//   busy           - arbiter currently owns the slave for some master
//   s_mem_ready    - slave completion strobe
//   expire         - high in the BUSY cycle that reaches TIMEOUT_CYCLES
//                    without a slave ready
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic busy,
  input  logic s_mem_ready,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // cnt_q holds the number of completed BUSY cycles without ready, so the
  // Nth BUSY cycle sees N-1 and that is where the limit is declared.
  assign expire = busy & ~s_mem_ready & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next count: cleared outside BUSY so each transaction starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (!busy) begin
      cnt_d = '0;
    end else if (s_mem_ready || expire) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave round-robin arbiter on the PicoRV32 native memory bus.
// m0 is the CPU, m1 the loader/debug master; the slave is the BRAM controller.
// A grant is held until the slave returns ready (or the owner drops valid),
// and every transaction is followed by one IDLE cycle for re-arbitration.
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   m0_mem_* / m1_mem_* - master request (valid/instr/addr/wdata/wstrb in,
//                         ready/rdata out)
//   s_mem_*             - slave request out, ready/rdata in
//   arb_err             - one-cycle timeout pulse
// Optional feature: MEM_ARB_TIMEOUT_EN enables a watchdog that completes a
// stalled access with ARB_ERR_RDATA after TIMEOUT_CYCLES BUSY cycles.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                m0_mem_valid,
  input  logic                m0_mem_instr,
  input  logic [ADDR_W-1:0]   m0_mem_addr,
  input  logic [DATA_W-1:0]   m0_mem_wdata,
  input  logic [DATA_W/8-1:0] m0_mem_wstrb,
  output logic                m0_mem_ready,
  output logic [DATA_W-1:0]   m0_mem_rdata,
  input  logic                m1_mem_valid,
  input  logic                m1_mem_instr,
  input  logic [ADDR_W-1:0]   m1_mem_addr,
  input  logic [DATA_W-1:0]   m1_mem_wdata,
  input  logic [DATA_W/8-1:0] m1_mem_wstrb,
  output logic                m1_mem_ready,
  output logic [DATA_W-1:0]   m1_mem_rdata,
  output logic                s_mem_valid,
  output logic                s_mem_instr,
  output logic [ADDR_W-1:0]   s_mem_addr,
  output logic [DATA_W-1:0]   s_mem_wdata,
  output logic [DATA_W/8-1:0] s_mem_wstrb,
  input  logic                s_mem_ready,
  input  logic [DATA_W-1:0]   s_mem_rdata,
  output logic                arb_err
);

  arb_state_t state_q, state_d;
  master_id_t last_grant_q, last_grant_d;

  logic busy;
  logic owner_valid;
  logic timeout_fire;
  logic complete;

  assign busy = (state_q == BUSY_M0) || (state_q == BUSY_M1);

`ifdef MEM_ARB_TIMEOUT_EN
  logic expire;

  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk        (clk),
    .reset_n    (reset_n),
    .busy       (busy),
    .s_mem_ready(s_mem_ready),
    .expire     (expire)
  );

  // A dropped valid already ends the access, so no error is raised for it.
  assign timeout_fire = expire & owner_valid;
`else
  // Watchdog limit has no meaning in this build.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
  assign timeout_fire = 1'b0;
`endif

  // Completion is only forwarded while the owner still requests.
  assign complete = owner_valid & (s_mem_ready | timeout_fire);
  assign arb_err  = timeout_fire;

  // Next-state and round-robin grant selection.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (m0_mem_valid && m1_mem_valid) begin
          if (last_grant_q == M1) begin
            state_d      = BUSY_M0;
            last_grant_d = M0;
          end else begin
            state_d      = BUSY_M1;
            last_grant_d = M1;
          end
        end else if (m0_mem_valid) begin
          state_d      = BUSY_M0;
          last_grant_d = M0;
        end else if (m1_mem_valid) begin
          state_d      = BUSY_M1;
          last_grant_d = M1;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_M0: begin
        if (!m0_mem_valid || s_mem_ready || timeout_fire) begin
          state_d = IDLE;
        end else begin
          state_d = BUSY_M0;
        end
      end
      BUSY_M1: begin
        if (!m1_mem_valid || s_mem_ready || timeout_fire) begin
          state_d = IDLE;
        end else begin
          state_d = BUSY_M1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and last-grant registers; M1 at reset so M0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= M1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Slave request mux, driven purely by the current owner.
  always_comb begin
    owner_valid = 1'b0;
    s_mem_instr = 1'b0;
    s_mem_addr  = '0;
    s_mem_wdata = '0;
    s_mem_wstrb = '0;
    case (state_q)
      BUSY_M0: begin
        owner_valid = m0_mem_valid;
        s_mem_instr = m0_mem_instr;
        s_mem_addr  = m0_mem_addr;
        s_mem_wdata = m0_mem_wdata;
        s_mem_wstrb = m0_mem_wstrb;
      end
      BUSY_M1: begin
        owner_valid = m1_mem_valid;
        s_mem_instr = m1_mem_instr;
        s_mem_addr  = m1_mem_addr;
        s_mem_wdata = m1_mem_wdata;
        s_mem_wstrb = m1_mem_wstrb;
      end
      default: begin
        owner_valid = 1'b0;
      end
    endcase
  end

  assign s_mem_valid = owner_valid;

  // Return path: zero-latency ready to the owner only, shared read data.
  always_comb begin
    m0_mem_ready = complete & (state_q == BUSY_M0);
    m1_mem_ready = complete & (state_q == BUSY_M1);
    if (timeout_fire) begin
      m0_mem_rdata = DATA_W'(ARB_ERR_RDATA);
      m1_mem_rdata = DATA_W'(ARB_ERR_RDATA);
    end else begin
      m0_mem_rdata = s_mem_rdata;
      m1_mem_rdata = s_mem_rdata;
    end
  end

endmodule
